// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// KEY_MAP is indexed [row][col].
package keypad_pkg;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESENT  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Telephone-style layout; '*' encodes as E and '#' as F.
  localparam logic [3:0] KEY_MAP [N_ROWS][N_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

endpackage

// File: rtl/keypad_scan_encoder_sync_2ff.sv
// Two-flop synchronizer that brings the asynchronous keypad rows into the clk domain.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s_p0;
  logic [W-1:0] s_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_p0 <= '0;
      s_p1 <= '0;
    end else begin
      s_p0 <= d;
      s_p1 <= s_p0;
    end
  end

  assign q = s_p1;

endmodule

// File: rtl/keypad_scan_encoder.sv
// Column-scanning 4x4 keypad encoder: debounces one key, encodes it to hex
// and hands it out on a valid/ack handshake, with release debounce.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 8,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  input  logic       key_ack_i,
  output logic       key_held_o
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

  logic [3:0]    rows;
  logic [DW-1:0] dwell_cnt;
  logic [1:0]    col_idx;
  logic          sample;
  logic [1:0]    low_row;
  logic          any_row;
  logic          scan_clean_nxt;

  state_t        state;
  logic [1:0]    cand_r;
  logic [1:0]    cand_c;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] rel_cnt;
  logic          rel_armed;
  logic          rel_clean;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    return (cnt >= CNT_MAX) ? CNT_MAX : cnt + CW'(1);
  endfunction

  sync_2ff #(.W(N_ROWS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_i),
    .q   (rows)
  );

  // Rows are judged only on the last dwell cycle, once the synchronizer has settled.
  assign sample  = (dwell_cnt == DW'(SCAN_DIV - 1));
  assign any_row = |rows;

  always_comb begin
    low_row = 2'd0;
    for (int r = N_ROWS - 1; r >= 0; r--) begin
      if (rows[r]) low_row = 2'(r);
    end
  end

  // A scan counts as clean only if every column sample since column 0 saw no rows.
  assign scan_clean_nxt = ((col_idx == 2'd0) ? 1'b1 : rel_clean) & ~any_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
      col_o     <= 4'b0001;
    end else if (sample) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 2'd1;
      col_o     <= {col_o[2:0], col_o[3]};
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      deb_cnt     <= '0;
      rel_cnt     <= '0;
      rel_armed   <= 1'b0;
      rel_clean   <= 1'b0;
      key_code_o  <= 4'h0;
      key_valid_o <= 1'b0;
      key_held_o  <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (sample && any_row) begin
            cand_r <= low_row;
            cand_c <= col_idx;
            if (DEBOUNCE_SCANS == 1) begin
              state       <= PRESENT;
              key_valid_o <= 1'b1;
              key_held_o  <= 1'b1;
              key_code_o  <= KEY_MAP[low_row][col_idx];
            end else begin
              state   <= DEBOUNCE;
              deb_cnt <= CW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (sample && col_idx == cand_c) begin
            if (any_row && low_row == cand_r) begin
              deb_cnt <= sat_inc(deb_cnt);
              if (deb_cnt == CNT_LAST) begin
                state       <= PRESENT;
                key_valid_o <= 1'b1;
                key_held_o  <= 1'b1;
                key_code_o  <= KEY_MAP[cand_r][cand_c];
              end
            end else begin
              state   <= SCAN;
              deb_cnt <= '0;
            end
          end
        end
        PRESENT: begin
          if (key_ack_i) begin
            state       <= RELEASE;
            key_valid_o <= 1'b0;
            deb_cnt     <= '0;
            rel_cnt     <= '0;
            rel_armed   <= 1'b0;
            rel_clean   <= 1'b0;
          end
        end
        RELEASE: begin
          if (sample) begin
            if (col_idx == 2'd0) rel_armed <= 1'b1;
            rel_clean <= scan_clean_nxt;
            if (any_row) begin
              rel_cnt <= '0;
            end else if (col_idx == 2'(N_COLS - 1) && rel_armed && scan_clean_nxt) begin
              if (rel_cnt == CNT_LAST) begin
                state      <= SCAN;
                key_held_o <= 1'b0;
                rel_cnt    <= '0;
              end else begin
                rel_cnt <= sat_inc(rel_cnt);
              end
            end
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
